// File: rtl/ntt_writeback.sv
// ntt_writeback
// Write-back stage of the NTT/INTT butterfly datapath. Butterfly result
// pairs arrive together with their pipeline-delayed bank addresses and a
// swap flag. Each accepted pair is registered once and steered into the
// two coefficient banks. Accepted pairs are counted per level. Pulses mark
// the completion of each level and of the whole transform.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, mode_intt      arm a new transform; mode sampled on start
//   abort                 synchronous abort back to IDLE (highest priority)
//   bf_valid, bf_a, bf_b  butterfly result pair and its valid
//   bf_addr0, bf_addr1    delayed write addresses for bank0 / bank1
//   bf_swap               delayed swap-write flag
//   mem0_*, mem1_*        registered bank write ports
//   busy                  high from start until the transform has landed
//   wr_level              level currently being written
//   level_done            pulse with the write of the last pair of a level
//   xform_done            pulse with the write of the last pair of the transform
//   mode_q                captured mode_intt
//   err                   sticky protocol error
module ntt_writeback #(
    parameter int DW     = 13,
    parameter int AW     = 11,
    parameter int PAIRS  = 32,
    parameter int LEVELS = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode_intt,
    input  logic          abort,
    input  logic          bf_valid,
    input  logic [DW-1:0] bf_a,
    input  logic [DW-1:0] bf_b,
    input  logic [AW-1:0] bf_addr0,
    input  logic [AW-1:0] bf_addr1,
    input  logic          bf_swap,
    output logic          mem0_we,
    output logic [AW-1:0] mem0_addr,
    output logic [DW-1:0] mem0_wdata,
    output logic          mem1_we,
    output logic [AW-1:0] mem1_addr,
    output logic [DW-1:0] mem1_wdata,
    output logic          busy,
    output logic [2:0]    wr_level,
    output logic          level_done,
    output logic          xform_done,
    output logic          mode_q,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] pair_cnt;
    logic       last_pair;
    logic       last_level;

    assign last_pair  = (pair_cnt == 5'(PAIRS - 1));
    assign last_level = (wr_level == 3'(LEVELS - 1));

    // Every output is a register; data registers are cleared as well so that
    // all outputs read 0 while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pair_cnt   <= '0;
            mem0_we    <= 1'b0;
            mem0_addr  <= '0;
            mem0_wdata <= '0;
            mem1_we    <= 1'b0;
            mem1_addr  <= '0;
            mem1_wdata <= '0;
            busy       <= 1'b0;
            wr_level   <= '0;
            level_done <= 1'b0;
            xform_done <= 1'b0;
            mode_q     <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Write enables and done flags are single-cycle pulses.
            mem0_we    <= 1'b0;
            mem1_we    <= 1'b0;
            level_done <= 1'b0;
            xform_done <= 1'b0;

            // wr_level shows the completed level during its pulse and moves
            // on the cycle after; the final level is held until restart.
            if (level_done && !xform_done)
                wr_level <= wr_level + 3'd1;

            if (abort) begin
                // Dropping the write enables above kills the pending write;
                // err is deliberately left untouched.
                state    <= IDLE;
                busy     <= 1'b0;
                pair_cnt <= '0;
                wr_level <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            mode_q   <= mode_intt;
                            pair_cnt <= '0;
                            wr_level <= '0;
                            // A pair arriving with start is dropped and flagged.
                            err      <= bf_valid;
                        end else if (bf_valid) begin
                            err <= 1'b1;
                        end
                    end

                    RUN: begin
                        if (start)
                            err <= 1'b1;
                        if (bf_valid) begin
                            mem0_we   <= 1'b1;
                            mem1_we   <= 1'b1;
                            mem0_addr <= bf_addr0;
                            mem1_addr <= bf_addr1;
                            // Swap exchanges the data only; addresses stay per bank.
                            mem0_wdata <= bf_swap ? bf_b : bf_a;
                            mem1_wdata <= bf_swap ? bf_a : bf_b;
                            if (last_pair) begin
                                pair_cnt   <= '0;
                                level_done <= 1'b1;
                                if (last_level) begin
                                    xform_done <= 1'b1;
                                    state      <= FLUSH;
                                end
                            end else begin
                                pair_cnt <= pair_cnt + 5'd1;
                            end
                        end
                    end

                    FLUSH: begin
                        // The last write is on the bank ports during this cycle.
                        if (start || bf_valid)
                            err <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ntt_writeback.sv
module tb_ntt_writeback;

    localparam int DW     = 13;
    localparam int AW     = 11;
    localparam int PAIRS  = 32;
    localparam int LEVELS = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, mode_intt, abort, bf_valid, bf_swap;
    logic [DW-1:0] bf_a, bf_b;
    logic [AW-1:0] bf_addr0, bf_addr1;
    logic          mem0_we, mem1_we, busy, level_done, xform_done, mode_q, err;
    logic [AW-1:0] mem0_addr, mem1_addr;
    logic [DW-1:0] mem0_wdata, mem1_wdata;
    logic [2:0]    wr_level;

    int n_cmp  = 0;
    int n_fail = 0;

    ntt_writeback #(.DW(DW), .AW(AW), .PAIRS(PAIRS), .LEVELS(LEVELS)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_intt(mode_intt), .abort(abort),
        .bf_valid(bf_valid), .bf_a(bf_a), .bf_b(bf_b),
        .bf_addr0(bf_addr0), .bf_addr1(bf_addr1), .bf_swap(bf_swap),
        .mem0_we(mem0_we), .mem0_addr(mem0_addr), .mem0_wdata(mem0_wdata),
        .mem1_we(mem1_we), .mem1_addr(mem1_addr), .mem1_wdata(mem1_wdata),
        .busy(busy), .wr_level(wr_level), .level_done(level_done),
        .xform_done(xform_done), .mode_q(mode_q), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counts accepted pairs over the whole transform and
    // derives level boundaries and the current level from that total.
    int            m_st;      // 0 idle, 1 run, 2 flush
    int            m_total;
    logic          e_we, e_ld, e_xd, e_busy, e_mode, e_err;
    logic [2:0]    e_lvl;
    logic [AW-1:0] e_a0, e_a1;
    logic [DW-1:0] e_d0, e_d1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_total = 0;
            e_we = 0; e_ld = 0; e_xd = 0; e_busy = 0; e_mode = 0; e_err = 0;
            e_lvl = 0; e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
        end else begin
            e_we = 0; e_ld = 0; e_xd = 0;
            if (abort) begin
                m_st = 0; m_total = 0; e_busy = 0;
            end else if (m_st == 0) begin
                if (start) begin
                    m_st = 1; m_total = 0; e_mode = mode_intt; e_busy = 1; e_err = bf_valid;
                end else if (bf_valid) begin
                    e_err = 1;
                end
            end else if (m_st == 1) begin
                if (start) e_err = 1;
                if (bf_valid) begin
                    e_we = 1;
                    e_a0 = bf_addr0; e_a1 = bf_addr1;
                    e_d0 = bf_swap ? bf_b : bf_a;
                    e_d1 = bf_swap ? bf_a : bf_b;
                    m_total++;
                    if (m_total % PAIRS == 0) begin
                        e_ld = 1;
                        if (m_total == PAIRS * LEVELS) begin
                            e_xd = 1; m_st = 2;
                        end
                    end
                end
            end else begin
                if (start || bf_valid) e_err = 1;
                m_st = 0; e_busy = 0;
            end
            if (e_ld) e_lvl = 3'(m_total / PAIRS - 1);
            else      e_lvl = 3'((m_total / PAIRS < LEVELS) ? m_total / PAIRS : LEVELS - 1);
        end
    end

    // Per-cycle comparison plus a log of done pulses.
    int ld_cnt = 0;
    int xd_cnt = 0;
    int xd_with_ld = 0;
    int ld_lvl [0:63];

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem0_we",    32'(mem0_we),    32'(e_we));
            chk("mem1_we",    32'(mem1_we),    32'(e_we));
            chk("mem0_addr",  32'(mem0_addr),  32'(e_a0));
            chk("mem1_addr",  32'(mem1_addr),  32'(e_a1));
            chk("mem0_wdata", 32'(mem0_wdata), 32'(e_d0));
            chk("mem1_wdata", 32'(mem1_wdata), 32'(e_d1));
            chk("busy",       32'(busy),       32'(e_busy));
            chk("wr_level",   32'(wr_level),   32'(e_lvl));
            chk("level_done", 32'(level_done), 32'(e_ld));
            chk("xform_done", 32'(xform_done), 32'(e_xd));
            chk("mode_q",     32'(mode_q),     32'(e_mode));
            chk("err",        32'(err),        32'(e_err));
            if (level_done) begin
                if (ld_cnt < 64) ld_lvl[ld_cnt] = int'(wr_level);
                if (xform_done) xd_with_ld++;
                ld_cnt++;
            end
            if (xform_done) xd_cnt++;
        end
    end

    task automatic cyc(input logic v, input logic s, input logic ab, input int i, input logic sw);
        @(negedge clk);
        bf_valid = v; start = s; abort = ab; bf_swap = sw;
        bf_a = DW'(i); bf_b = DW'(100 + i);
        bf_addr0 = AW'(i); bf_addr1 = AW'(i + 32);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem0_we"},    32'(mem0_we),    32'd0);
        chk({tag, "_mem1_we"},    32'(mem1_we),    32'd0);
        chk({tag, "_mem0_addr"},  32'(mem0_addr),  32'd0);
        chk({tag, "_mem1_wdata"}, 32'(mem1_wdata), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_wr_level"},   32'(wr_level),   32'd0);
        chk({tag, "_mode_q"},     32'(mode_q),     32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
    endtask

    int ld0, xd0, xl0;

    initial begin
        rst = 1'b1; start = 0; mode_intt = 0; abort = 0; bf_valid = 0; bf_swap = 0;
        bf_a = 0; bf_b = 0; bf_addr0 = 0; bf_addr1 = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        idle();

        // bf_valid while idle: no write, error flagged
        cyc(1'b1, 1'b0, 1'b0, 7, 1'b0);
        idle();
        chk("idle_valid_we",  32'(mem0_we), 32'd0);
        chk("idle_valid_err", 32'(err),     32'd1);

        // start clears the error and enters RUN (NTT)
        mode_intt = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle();
        chk("start_err",  32'(err),  32'd0);
        chk("start_busy", 32'(busy), 32'd1);

        // level 0: 32 back-to-back straight pairs
        for (int i = 0; i < PAIRS; i++) cyc(1'b1, 1'b0, 1'b0, i, 1'b0);
        idle();
        chk("l0_mem0_addr",  32'(mem0_addr),  32'd31);
        chk("l0_mem0_wdata", 32'(mem0_wdata), 32'd31);
        chk("l0_mem1_addr",  32'(mem1_addr),  32'd63);
        chk("l0_mem1_wdata", 32'(mem1_wdata), 32'd131);
        chk("l0_level_done", 32'(level_done), 32'd1);
        chk("l0_wr_level",   32'(wr_level),   32'd0);
        idle();
        chk("l0_level_next", 32'(wr_level),   32'd1);
        chk("l0_done_off",   32'(level_done), 32'd0);

        // level 1: swap on odd pairs
        for (int i = 0; i < PAIRS; i++) begin
            cyc(1'b1, 1'b0, 1'b0, i, 1'(i % 2));
            if (i == 5 || i == 6) begin
                idle();
                chk("swap_mem0_addr",  32'(mem0_addr),  32'(i));
                chk("swap_mem0_wdata", 32'(mem0_wdata), (i == 5) ? 32'd105 : 32'd6);
                chk("swap_mem1_wdata", 32'(mem1_wdata), (i == 5) ? 32'd5 : 32'd106);
            end
        end
        idle();
        idle();
        chk("l1_wr_level", 32'(wr_level), 32'd2);

        // level 2: abort after 10 pairs, arriving together with an 11th pair
        ld0 = ld_cnt;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, i, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 10, 1'b0);
        idle();
        chk("abort_we",       32'(mem0_we),     32'd0);
        chk("abort_busy",     32'(busy),        32'd0);
        chk("abort_wr_level", 32'(wr_level),    32'd0);
        chk("abort_no_done",  32'(ld_cnt - ld0), 32'd0);

        // full INTT transform with random gaps and a stray start mid-run
        mode_intt = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle();
        chk("intt_mode_q", 32'(mode_q), 32'd1);
        ld0 = ld_cnt; xd0 = xd_cnt; xl0 = xd_with_ld;
        for (int k = 0; k < PAIRS * LEVELS; k++) begin
            if (k > 0) repeat ($urandom_range(0, 2)) idle();
            cyc(1'b1, 1'(k == 50), 1'b0, k % PAIRS, 1'(k % 3 == 0));
        end
        idle();
        chk("flush_busy",  32'(busy),       32'd1);
        chk("flush_xform", 32'(xform_done), 32'd1);
        idle();
        chk("done_busy_low",   32'(busy),         32'd0);
        chk("done_level_cnt",  32'(ld_cnt - ld0), 32'd6);
        chk("done_xform_cnt",  32'(xd_cnt - xd0), 32'd1);
        chk("done_xform_pair", 32'(xd_with_ld - xl0), 32'd1);
        for (int j = 0; j < LEVELS; j++)
            if (ld0 + j < 64) chk("done_level_seq", 32'(ld_lvl[ld0 + j]), 32'(j));
        chk("stray_start_err", 32'(err), 32'd1);

        // reset in the middle of level 3
        mode_intt = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3 * PAIRS + 17; k++) cyc(1'b1, 1'b0, 1'b0, k % PAIRS, 1'b0);
        idle();
        chk("pre_rst_we",    32'(mem0_we),  32'd1);
        chk("pre_rst_level", 32'(wr_level), 32'd3);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        mode_intt = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < PAIRS; i++) cyc(1'b1, 1'b0, 1'b0, i, 1'b0);
        idle();
        chk("post_rst_done",  32'(level_done), 32'd1);
        chk("post_rst_level", 32'(wr_level),   32'd0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
